// File: rtl/acc_core_sequencer_if.sv
// Shared instruction/data memory port. The core is the master and the memory is the slave.
// The slave may hold mem_ack low for any number of wait cycles.
interface acc_core_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/acc_core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator machine.
// It owns PC/IR/MAR/MBR/AC and runs one shared memory through a req/ack handshake.
module acc_core_sequencer #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  acc_core_sequencer_if.master    mem,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0]   acc,
  output logic                    retired,
  output logic                    halted,
  output logic                    illegal
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1, OP_STORE = 4'h2, OP_ADD  = 4'h3, OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5, OP_OR    = 4'h6, OP_XOR  = 4'h7, OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9, OP_JN    = 4'hA, OP_SHL  = 4'hB, OP_SHR   = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hD, OP_ILL   = 4'hE, OP_HALT = 4'hF;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d, ir_q, ir_d, mbr_q, mbr_d;
  logic                  illegal_q, illegal_d;
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] operand_zx;
  logic                  req, we;
  logic [ADDR_WIDTH-1:0] addr;

  assign opcode     = ir_q[DATA_WIDTH-1 -: 4];
  assign operand_zx = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, mar_q};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      mar_q     <= '0;
      ac_q      <= '0;
      ir_q      <= '0;
      mbr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ac_q      <= ac_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    ac_d      = ac_q;
    ir_d      = ir_q;
    mbr_d     = mbr_q;
    illegal_d = illegal_q;
    req       = 1'b0;
    we        = 1'b0;
    addr      = pc_q;
    retired   = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        pc_d  = pc_q + ADDR_WIDTH'(1);
        mar_d = ir_q[ADDR_WIDTH-1:0];
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_MEM;
          OP_ILL: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_MEM: begin
        // Address, direction and write data come from registers frozen for the whole request.
        req  = 1'b1;
        addr = mar_q;
        we   = (opcode == OP_STORE);
        if (mem.mem_ack) begin
          if (opcode == OP_STORE) begin
            retired = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            mbr_d   = mem.mem_rdata;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        retired = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
        case (opcode)
          OP_LOAD:  ac_d = mbr_q;
          OP_ADD:   ac_d = ac_q + mbr_q;
          OP_SUB:   ac_d = ac_q - mbr_q;
          OP_AND:   ac_d = ac_q & mbr_q;
          OP_OR:    ac_d = ac_q | mbr_q;
          OP_XOR:   ac_d = ac_q ^ mbr_q;
          OP_JUMP:  pc_d = mar_q;
          OP_JZ:    if (ac_q == '0) pc_d = mar_q;
          OP_JN:    if (ac_q[DATA_WIDTH-1]) pc_d = mar_q;
          OP_SHL:   ac_d = {ac_q[DATA_WIDTH-2:0], 1'b0};
          OP_SHR:   ac_d = {1'b0, ac_q[DATA_WIDTH-1:1]};
          OP_LOADI: ac_d = operand_zx;
          default:  ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = ac_q;
  assign pc            = pc_q;
  assign acc           = ac_q;
  assign halted        = (state_q == S_HALT);
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_acc_core_sequencer.sv
// Bench for acc_core_sequencer: an instruction-level model with phase timing, directed programs and random programs.
module tb_acc_core_sequencer;
  localparam int            DW  = 16;
  localparam int            AW  = 12;
  localparam logic [AW-1:0] RPC = 12'hFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          run   = 1'b0;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic          retired, halted, illegal;

  acc_core_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  acc_core_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .run(run), .mem(mif.master),
    .pc(pc), .acc(acc), .retired(retired), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Memory responder: loads the program image during reset, then serves requests with wait states.
  logic [DW-1:0] prog [0:(1<<AW)-1];
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  int  wcnt = 0, cur_wait = 0, wait_max = 0;
  bit  wait_fixed = 1'b1, noise_en = 1'b0, noise_bit = 1'b0;

  assign mif.mem_rdata = mem[mif.mem_addr];
  assign mif.mem_ack   = mif.mem_req ? (wcnt >= cur_wait) : (noise_en & noise_bit);

  always @(posedge clock) begin
    if (!reset) mem <= prog;
    else if (mif.mem_req && mif.mem_we && mif.mem_ack) mem[mif.mem_addr] <= mif.mem_wdata;
    if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
    else begin
      wcnt     <= 0;
      cur_wait <= wait_fixed ? wait_max : int'($urandom_range(0, wait_max));
    end
    noise_bit <= 1'($urandom_range(0, 1));
  end

  // Retire snapshots and latency markers, cleared while reset is low.
  int  cyc = 0, f0_cyc = 0, h_cyc = 0;
  bit  f0_seen = 1'b0, h_seen = 1'b0, ret_seen = 1'b0;
  logic [AW-1:0] rpc [$];
  logic [DW-1:0] racc [$];

  always @(posedge clock) ret_seen <= reset && retired;

  always @(negedge clock) begin
    if (!reset) begin
      cyc <= 0; f0_cyc <= 0; h_cyc <= 0; f0_seen <= 1'b0; h_seen <= 1'b0;
      rpc.delete(); racc.delete();
    end else begin
      cyc <= cyc + 1;
      if (!f0_seen && mif.mem_req && !mif.mem_we && mif.mem_addr == '0) begin
        f0_seen <= 1'b1; f0_cyc <= cyc;
      end
      if (!h_seen && halted) begin h_seen <= 1'b1; h_cyc <= cyc; end
      if (ret_seen) begin rpc.push_back(pc); racc.push_back(acc); end
    end
  end

  // Architectural model state.
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  bit            m_halt, m_ill;
  logic [DW-1:0] mm [0:(1<<AW)-1];
  bit            rand_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares one cycle at the negedge, optionally re-rolls run, then advances one cycle.
  task automatic step(input bit e_req, input bit e_we, input logic [AW-1:0] e_addr, input bit e_ret);
    chk("mem_req", mif.mem_req, e_req);
    if (e_req) begin
      chk("mem_addr", mif.mem_addr, e_addr);
      chk("mem_we", mif.mem_we, e_we);
      if (e_we) chk("mem_wdata", mif.mem_wdata, m_acc);
    end
    chk("retired", retired, e_ret);
    chk("pc", pc, m_pc);
    chk("acc", acc, m_acc);
    chk("halted", halted, m_halt);
    chk("illegal", illegal, m_ill);
    if (rand_run) run = ($urandom_range(0, 3) != 0);
    @(negedge clock);
  endtask

  task automatic req_phase(input logic [AW-1:0] a, input bit w, output bit ok);
    int n = 0;
    bit ack;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      ack = mif.mem_ack;
      step(1'b1, w, a, w && ack);
      n++;
      ok = ack;
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL ack_wait: no ack after %0d cycles at addr %0h, required within 40", n, a);
    end
  endtask

  task automatic run_model(input int max_instr);
    bit            need_idle = 1'b1;
    bit            ok;
    logic [DW-1:0] ir, mbr;
    logic [3:0]    op;
    logic [AW-1:0] x;
    int            ni = 0;
    int            k;
    while (!m_halt && ni < max_instr) begin
      if (need_idle) begin
        k = 0;
        do begin step(1'b0, 1'b0, '0, 1'b0); k++; end while (!run && k < 50);
        if (!run) return;
      end
      req_phase(m_pc, 1'b0, ok);
      if (!ok) return;
      ir = mm[m_pc];
      step(1'b0, 1'b0, '0, 1'b0);
      m_pc = m_pc + 1'b1;
      op = ir[DW-1 -: 4];
      x  = ir[AW-1:0];
      mbr = '0;
      ni++;
      if (op == 4'hE || op == 4'hF) begin
        m_halt = 1'b1;
        m_ill  = (op == 4'hE);
      end else begin
        if (op >= 4'h1 && op <= 4'h7) begin
          req_phase(x, op == 4'h2, ok);
          if (!ok) return;
          if (op == 4'h2) mm[x] = m_acc;
          else mbr = mm[x];
        end
        if (op != 4'h2) begin
          step(1'b0, 1'b0, '0, 1'b1);
          case (op)
            4'h1: m_acc = mbr;
            4'h3: m_acc = m_acc + mbr;
            4'h4: m_acc = m_acc - mbr;
            4'h5: m_acc = m_acc & mbr;
            4'h6: m_acc = m_acc | mbr;
            4'h7: m_acc = m_acc ^ mbr;
            4'h8: m_pc = x;
            4'h9: if (m_acc == '0) m_pc = x;
            4'hA: if (m_acc[DW-1]) m_pc = x;
            4'hB: m_acc = m_acc << 1;
            4'hC: m_acc = m_acc >> 1;
            4'hD: m_acc = {{(DW-AW){1'b0}}, x};
            default: ;
          endcase
        end
        need_idle = !run;
      end
    end
    if (m_halt) repeat (8) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_acc", acc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    m_pc = RPC; m_acc = '0; m_halt = 1'b0; m_ill = 1'b0;
    mm = prog;
    reset = 1'b1;
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input int max_cyc, input string name);
    int n = 0;
    while (!(mif.mem_req && mif.mem_addr == a) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(mif.mem_req && mif.mem_addr == a), 1);
  endtask

  task automatic basic_prog();
    clear_prog();
    prog[12'hFFF] = 16'h0000;
    prog[12'h000] = 16'h1010; prog[12'h001] = 16'h3011;
    prog[12'h002] = 16'h2012; prog[12'h003] = 16'hF000;
    prog[12'h010] = 16'h0005; prog[12'h011] = 16'h0007;
  endtask

  task automatic basic_checks(input string tag, input int cycles);
    chk({tag, "_store"}, mem[12'h012], 16'h000C);
    chk({tag, "_acc"}, acc, 16'h000C);
    chk({tag, "_pc"}, pc, 12'h004);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_retires"}, rpc.size(), 4);
    chk({tag, "_wrap_pc"}, rpc[0], 12'h000);
    chk({tag, "_latency"}, h_cyc - f0_cyc, cycles);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait memory: 4+4+3+2 cycles from the fetch at address 0 to HALT.
    basic_prog();
    wait_fixed = 1'b1; wait_max = 0; noise_en = 1'b0; rand_run = 1'b0;
    do_reset(); run = 1'b1; run_model(20);
    basic_checks("zw", 13);

    // Three wait cycles on each of the 7 requests from address 0 onward.
    basic_prog();
    wait_max = 3;
    do_reset(); run = 1'b1; run_model(20);
    basic_checks("ws3", 13 + 7 * 3);

    // LOADI 3, SUB 5 underflows, JN taken.
    clear_prog();
    prog[12'h000] = 16'hD003; prog[12'h001] = 16'h4020; prog[12'h002] = 16'hA030;
    prog[12'h020] = 16'h0005; prog[12'h030] = 16'hF000;
    wait_fixed = 1'b0; wait_max = 3; noise_en = 1'b1;
    do_reset(); run = 1'b1; run_model(20);
    chk("jn_retires", rpc.size(), 4);
    chk("jn_pc", rpc[3], 12'h030);
    chk("jn_acc", racc[3], 16'hFFFE);

    // JZ taken with AC = 0.
    clear_prog();
    prog[12'h000] = 16'hD000; prog[12'h001] = 16'h9040; prog[12'h040] = 16'hF000;
    do_reset(); run = 1'b1; run_model(20);
    chk("jz_taken_pc", rpc[2], 12'h040);

    // JZ not taken with AC = 1.
    clear_prog();
    prog[12'h001] = 16'hD001; prog[12'h002] = 16'h9040; prog[12'h003] = 16'hF000;
    do_reset(); run = 1'b1; run_model(20);
    chk("jz_fall_pc", rpc[3], 12'h003);

    // Illegal opcode with run toggling afterwards.
    clear_prog();
    prog[12'h000] = 16'hE000;
    rand_run = 1'b1;
    do_reset(); run = 1'b1; run_model(20);
    chk("ill_illegal", illegal, 1);
    chk("ill_halted", halted, 1);
    chk("ill_pc", pc, 12'h001);
    chk("ill_retires", rpc.size(), 1);
    rand_run = 1'b0;

    // Dropping run during a LOAD lets it retire, then the core idles.
    clear_prog();
    prog[12'h000] = 16'h1010; prog[12'h001] = 16'h1011; prog[12'h010] = 16'h0005;
    wait_fixed = 1'b1; wait_max = 2; noise_en = 1'b0;
    do_reset(); run = 1'b1;
    wait_req(12'h000, 60, "run_fetch_seen");
    run = 1'b0;
    for (int n = 0; n < 40 && rpc.size() < 2; n++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk("run_retires", rpc.size(), 2);
    chk("run_req_idle", mif.mem_req, 0);
    chk("run_acc", acc, 16'h0005);
    chk("run_pc", pc, 12'h001);
    chk("run_halted", halted, 0);

    // Reset while a data read is pending and unacknowledged.
    clear_prog();
    prog[12'hFFF] = 16'hD123; prog[12'h000] = 16'h1010;
    wait_max = 30;
    do_reset(); run = 1'b1;
    wait_req(12'h010, 150, "rst_mem_seen");
    repeat (2) @(negedge clock);
    chk("rst_mem_pending", mif.mem_req, 1);
    chk("rst_acc_before", acc, 16'h0123);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_req", mif.mem_req, 0);
    chk("rst_mid_pc", pc, RPC);
    chk("rst_mid_acc", acc, 0);
    chk("rst_mid_halted", halted, 0);
    reset = 1'b1; run = 1'b1;
    @(negedge clock);
    chk("rst_restart_req", mif.mem_req, 1);
    chk("rst_restart_addr", mif.mem_addr, RPC);
    chk("rst_restart_we", mif.mem_we, 0);

    // Random programs in a 64-word window, random waits, run toggling and stray acks.
    wait_fixed = 1'b0; noise_en = 1'b1; rand_run = 1'b1;
    for (int it = 0; it < 20; it++) begin
      clear_prog();
      for (int a = 0; a < 64; a++) begin
        logic [3:0] op;
        int r;
        r  = $urandom_range(0, 99);
        op = (r < 3) ? 4'hF : (r < 5) ? 4'hE : 4'($urandom_range(0, 13));
        prog[a] = {op, 12'($urandom_range(0, 63))};
      end
      prog[12'hFFF] = {4'($urandom_range(0, 13)), 12'($urandom_range(0, 63))};
      for (int a = 40; a < 64; a++) if ($urandom_range(0, 1) == 1) prog[a] = 16'($urandom);
      wait_max = $urandom_range(0, 3);
      do_reset(); run = 1'b1; run_model(60);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
